// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared load/store types, FSM encoding and strobe/legality helpers.
// Revision : 1.0
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_SB = 2'b00,
        ST_SH = 2'b01,
        ST_SW = 2'b10
    } store_type_e;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } load_type_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SETUP  = 2'b01,
        S_ACCESS = 2'b10,
        S_RESP   = 2'b11
    } state_e;

    function automatic logic [3:0] lsu_strobe(input logic [1:0] store_type,
                                              input logic [1:0] offset);
        logic [3:0] strb;
        case (store_type)
            ST_SB:   strb = 4'b0001 << offset;
            ST_SH:   strb = 4'b0011 << {offset[1], 1'b0};
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // Unknown type codes and accesses not naturally aligned to their size.
    function automatic logic lsu_illegal(input logic       we,
                                         input logic [1:0] offset,
                                         input logic [1:0] store_type,
                                         input logic [2:0] load_type);
        logic bad;
        if (we) begin
            case (store_type)
                ST_SB:   bad = 1'b0;
                ST_SH:   bad = offset[0];
                ST_SW:   bad = |offset;
                default: bad = 1'b1;
            endcase
        end else begin
            case (load_type)
                LD_LB, LD_LBU: bad = 1'b0;
                LD_LH, LD_LHU: bad = offset[0];
                LD_LW:         bad = |offset;
                default:       bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_load_align
// Purpose  : Selects the addressed byte/halfword lane of PRDATA and extends it.
// Revision : 1.0
// ============================================================================
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] prdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  load_type,
    output logic [31:0] data
);

    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_shifted = prdata >> {offset, 3'b000};
        w_byte    = w_shifted[7:0];
        w_half    = offset[1] ? prdata[31:16] : prdata[15:0];
        case (load_type)
            LD_LB:   data = {{24{w_byte[7]}}, w_byte};
            LD_LH:   data = {{16{w_half[15]}}, w_half};
            LD_LBU:  data = {24'h0, w_byte};
            LD_LHU:  data = {16'h0, w_half};
            default: data = prdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : lsu_apb_master
// Purpose  : Turns one core load/store request into a single APB transfer.
// Revision : 1.0
// ============================================================================
module lsu_apb_master
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  storeType,
    input  logic [2:0]  loadType,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] PADDR,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    output logic [3:0]  PSTRB,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e             r_state;
    logic               r_we;
    logic [1:0]         r_offset;
    logic [2:0]         r_load_type;
    logic [c_CNT_W-1:0] r_wait_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [31:0]        r_rdata;
    logic [31:0]        r_paddr;
    logic               r_psel;
    logic               r_penable;
    logic               r_pwrite;
    logic [31:0]        r_pwdata;
    logic [3:0]         r_pstrb;

    logic [31:0]        w_pwdata;
    logic [31:0]        w_load_data;
    logic               w_illegal;

    always_comb begin
        w_illegal = lsu_illegal(we, addr[1:0], storeType, loadType);
        case (storeType)
            ST_SB:   w_pwdata = {4{wdata[7:0]}};
            ST_SH:   w_pwdata = {2{wdata[15:0]}};
            default: w_pwdata = wdata;
        endcase
    end

    lsu_load_align u_load_align (
        .prdata    (PRDATA),
        .offset    (r_offset),
        .load_type (r_load_type),
        .data      (w_load_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_offset    <= 2'b00;
            r_load_type <= 3'b000;
            r_wait_cnt  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= 32'h0;
            r_paddr     <= 32'h0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= 32'h0;
            r_pstrb     <= 4'h0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_busy      <= 1'b1;
                        r_we        <= we;
                        r_offset    <= addr[1:0];
                        r_load_type <= loadType;
                        r_wait_cnt  <= '0;
                        r_rdata     <= 32'h0;
                        if (w_illegal) begin
                            // Rejected without any bus activity.
                            r_state <= S_RESP;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state   <= S_SETUP;
                            r_err     <= 1'b0;
                            r_psel    <= 1'b1;
                            r_penable <= 1'b0;
                            r_paddr   <= {addr[31:2], 2'b00};
                            r_pwrite  <= we;
                            r_pwdata  <= we ? w_pwdata : 32'h0;
                            r_pstrb   <= we ? lsu_strobe(storeType, addr[1:0]) : 4'h0;
                        end
                    end
                end
                S_SETUP: begin
                    r_state   <= S_ACCESS;
                    r_penable <= 1'b1;
                end
                S_ACCESS: begin
                    if (PREADY) begin
                        r_state    <= S_RESP;
                        r_psel     <= 1'b0;
                        r_penable  <= 1'b0;
                        r_done     <= 1'b1;
                        r_err      <= PSLVERR;
                        r_rdata    <= (PSLVERR || r_we) ? 32'h0 : w_load_data;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == c_CNT_W'(TIMEOUT_CYCLES)) begin
                        r_state    <= S_RESP;
                        r_psel     <= 1'b0;
                        r_penable  <= 1'b0;
                        r_done     <= 1'b1;
                        r_err      <= 1'b1;
                        r_rdata    <= 32'h0;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_err   <= 1'b0;
                    r_rdata <= 32'h0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;
    assign rdata   = r_rdata;
    assign PADDR   = r_paddr;
    assign PSEL    = r_psel;
    assign PENABLE = r_penable;
    assign PWRITE  = r_pwrite;
    assign PWDATA  = r_pwdata;
    assign PSTRB   = r_pstrb;

endmodule
`default_nettype wire

// File: doc/lsu_apb_master.md
# lsu_apb_master

Load/store initiator that turns one core memory request (address, store/load type, write data) into a single APB transfer toward DataMemory, GPIO and other APB peripherals. Generates byte strobes and lane-replicated write data for SB/SH/SW, extracts and sign/zero-extends load data for LB/LH/LW/LBU/LHU, rejects misaligned or illegal requests without touching the bus, and aborts stalled transfers after a bounded wait. Sits between the core's execute/memory stage and the APB interconnect.

## Interface
- TIMEOUT_CYCLES, default 16: max ACCESS cycles waiting on PREADY before abort (>=1).
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- req  input  1  request strobe from core, sampled only in IDLE
- we  input  1  1 = store, 0 = load
- addr  input  32  byte address
- wdata  input  32  store data, right-aligned
- storeType  input  2  SB=00, SH=01, SW=10 (11 illegal)
- loadType  input  3  LB=000, LH=001, LW=010, LBU=100, LHU=101 (others illegal)
- busy  output  1  high from cycle after accepted req through the done cycle
- done  output  1  one-cycle completion pulse
- err  output  1  valid with done: misaligned, illegal type, PSLVERR or timeout
- rdata  output  32  extended load data, valid with done on a successful load, else 0
- PADDR  output  32  {addr[31:2],2'b00}
- PSEL, PENABLE, PWRITE  output  1 each  APB control
- PWDATA  output  32  lane-replicated write data
- PSTRB  output  4  byte strobes (0000 for loads)
- PRDATA  input  32  read data
- PREADY, PSLVERR  input  1 each  completer handshake / error

## Operation
- FSM: IDLE, SETUP, ACCESS, RESP.
- IDLE: on req=1 latch we/addr/wdata/types/offset = addr[1:0]. Legal -> SETUP; illegal -> RESP with err=1, no bus activity.
- Illegal: storeType=11 (we=1); loadType in {011,110,111} (we=0); SH/LH/LHU with addr[0]=1; SW/LW with addr[1:0]!=00.
- SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB driven; always -> ACCESS.
- ACCESS: PSEL=1, PENABLE=1, all bus outputs held stable. PREADY=1 -> RESP, capturing PRDATA and err=PSLVERR. Else wait counter increments; reaching TIMEOUT_CYCLES without PREADY -> RESP with err=1, PSEL/PENABLE deasserted.
- RESP: done=1 one cycle, then IDLE. req during busy/RESP ignored (not queued).
- Strobes: SB 0001<<offset; SH 0011<<{offset[1],0}; SW 1111.
- PWDATA: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
- Load lane: byte = PRDATA[8*offset +: 8], half = PRDATA[16*offset[1] +: 16]. LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
- On err: rdata=0. On store: rdata=0.

## Timing
- Req sampled at edge 0 -> SETUP in cycle 1 -> ACCESS cycle 2 -> done cycle 3 with zero wait states. Each wait state adds one cycle. Illegal request: done+err in cycle 1.
- Timeout: done at cycle 2+TIMEOUT_CYCLES+1 after req edge.
- done, err, rdata registered; all APB outputs registered (glitch-free).
- Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, busy=0, done=0, err=0, rdata=0, FSM=IDLE, wait counter=0.
- Reset mid-transfer: bus outputs drop to 0 immediately (async), no done pulse issued for the aborted request.
- PREADY in SETUP is ignored. PSLVERR is sampled only with PREADY=1 in ACCESS.

## Structure
- Shared package lsu_pkg: storeType/loadType enums (same codes as RV32I funct3), FSM state enum, helper function for strobe generation.
- One sub-module natural: lsu_load_align (combinational lane select + extension from PRDATA, offset, loadType); FSM, counter and strobe/replication logic in the top.

## Test plan
- SW addr=0x0000_0010, wdata=0xDEAD_BEEF, PREADY=1 -> PADDR=0x10, PSTRB=1111, PWDATA=0xDEADBEEF, done cycle 3, err=0.
- SB addr=0x13, wdata=0x0000_00A5 -> PSTRB=1000, PWDATA=0xA5A5A5A5; SH addr=0x22, wdata=0x1234 -> PSTRB=1100, PWDATA=0x12341234.
- PRDATA=0x80F0_7F81: LB addr=0x00 -> 0xFFFFFF81; LBU addr=0x00 -> 0x00000081; LH addr=0x02 -> 0xFFFF80F0; LHU addr=0x02 -> 0x000080F0; LW -> 0x80F07F81.
- LW addr=0x06 and SH addr=0x05 and storeType=11 -> done+err in cycle 1, PSEL never asserted.
- PREADY low 3 cycles then high with PSLVERR=1 -> done at cycle 6, err=1, rdata=0; PREADY never high, TIMEOUT_CYCLES=16 -> done+err at cycle 19, PSEL low.
- reset asserted in ACCESS -> PSEL/PENABLE/busy 0 immediately, no done; next req after release completes normally.
